alu_sequencer: RTL and testbench
================================

# alu_sequencer

- Sits directly upstream and downstream of the 16-bit ALU.
- Accepts one operation request on a valid/ready handshake and registers the operands, select code and carry-in onto the ALU inputs.
- Asserts the ALU enable so the ALU drives its tri-state result bus, then captures the result and flags.
- Presents the captured result on a valid/ready output handshake and keeps sticky carry/zero flags for carry-chained arithmetic.

## Interface
- DATA_W, 16, operand/result width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  request present
- cmd_ready  out  1  sequencer can accept a request
- cmd_op  in  3  ALU select code, passed through unmodified
- cmd_use_carry  in  1  1: alu_carry_in = flag_carry, 0: alu_carry_in = 0
- cmd_a  in  DATA_W  first operand
- cmd_b  in  DATA_W  second operand
- alu_in_1  out  DATA_W  ALU first operand
- alu_in_2  out  DATA_W  ALU second operand
- alu_select  out  3  ALU select code
- alu_carry_in  out  1  ALU carry-in
- alu_enable  out  1  ALU output enable
- alu_data  in  DATA_W  ALU result bus; high-Z when alu_enable = 0
- alu_carry_out  in  1  ALU carry-out
- alu_zero_flag  in  1  ALU zero flag
- res_valid  out  1  captured result available
- res_ready  in  1  consumer takes the result
- res_data  out  DATA_W  captured result
- res_carry  out  1  captured carry-out
- res_zero  out  1  captured zero flag
- flag_carry  out  1  sticky carry from the last completed operation
- flag_zero  out  1  sticky zero from the last completed operation

## Operation
- States: IDLE, DRIVE, SETTLE (only when configured), HOLD.
- **IDLE**
  - cmd_ready = 1.
  - alu_enable = 0; all alu_* outputs are 0.
  - On cmd_valid: register cmd_a, cmd_b, cmd_op and the resolved carry-in onto the alu_* outputs, then go to DRIVE.
- **DRIVE**
  - alu_enable = 1; alu_* outputs held stable.
  - On the exiting clock edge (or the SETTLE exit edge when configured):
    - alu_data is captured into res_data;
    - alu_carry_out into res_carry and flag_carry;
    - alu_zero_flag into res_zero and flag_zero.
  - Next state is HOLD.
- **HOLD**
  - res_valid = 1; alu_enable = 0; alu_* outputs return to 0.
  - On res_ready: go to IDLE; res_valid drops next cycle.
  - res_data, res_carry and res_zero stay stable while waiting.
- Requests are not pipelined:
  - cmd_ready = 0 outside IDLE;
  - cmd_valid there is ignored, with no side effects.
- flag_carry and flag_zero change only at a capture edge.
  - They persist across IDLE/HOLD, so a later cmd_use_carry = 1 chains carry.
- Result width is exactly DATA_W. alu_data is never sampled while alu_enable = 0.

## Timing
- Reset, asynchronous:
  - state = IDLE;
  - every output is 0 except cmd_ready = 1;
  - alu_enable drops immediately, without waiting for a clock, so the bus floats.
- Reset during DRIVE, SETTLE or HOLD abandons the operation:
  - the result is lost;
  - flags clear to 0.
- Cycle numbering: edge E0 accepts the request (cmd_valid & cmd_ready).
  - After E0: alu_enable = 1.
  - Capture at E1.
  - res_valid = 1 after E1.
- Accept-to-res_valid latency: 2 cycles, or 3 with settle.
- With res_ready held at 1: HOLD lasts 1 cycle. Minimum issue interval is 3 cycles, or 4 with settle.
- alu_enable is high for exactly 1 cycle per operation, or 2 with settle.
- alu_* outputs never change while alu_enable = 1.

## Configuration
- ALU_SEQ_SETTLE_EN
  - Defined: adds the SETTLE state after DRIVE. alu_enable and the operands are held one more cycle, and capture happens at the SETTLE exit edge.
  - Undefined: DRIVE goes directly to HOLD, and the SETTLE encoding is absent.

## Structure
- Shared package alu_seq_pkg:
  - state enum;
  - ALU op-code constants: ADD = 3'd0, SUB = 3'd1, NOT_A = 3'd5, OP7 = 3'd7;
  - DATA_W default.
- Sub-module alu_seq_flags:
  - capture register for res_data, res_carry, res_zero, flag_carry and flag_zero;
  - capture-enable input and async clear.
- FSM and handshake logic stay in alu_sequencer.

## Test plan
Each scenario runs against the real ALU.
- Reset: all outputs 0, cmd_ready = 1, alu_data reads high-Z. Then op 0, a = 5, b = 3 -> res_data = 8, res_carry = 0, res_zero = 0, 2 cycles after accept.
- op 1, a = 6035, b = 3127 -> res_data = 2908, res_carry = 0, res_zero = 0. Hold res_ready low 5 cycles: outputs stable, cmd_ready = 0, a cmd_valid pulse is ignored.
- op 5, a = 16'hFFFF, b = 0 -> res_data = 0, res_carry = 1, res_zero = 1, flag_carry = 1. Next, op 0, a = 4941, b = 1259, cmd_use_carry = 1 -> alu_carry_in = 1, res_data = 6201.
- op 7, a = 1, b = 0 -> res_data = 0, res_carry = 0, res_zero = 1. Check alu_enable is high for exactly 1 cycle, or 2 with ALU_SEQ_SETTLE_EN.
- Assert reset_n low during DRIVE -> alu_enable low before the next edge, flags 0, no res_valid pulse. The next request completes normally.
- Back-to-back requests with res_ready tied to 1 -> an accept every 3 cycles (4 with settle), no lost or duplicated results.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM state codes, ALU op-codes and default width.
// Optional SETTLE state is enabled by defining ALU_SEQ_SETTLE_EN.
package alu_seq_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;

  // ALU select codes passed straight through to the ALU
  localparam logic [2:0] ADD   = 3'd0;
  localparam logic [2:0] SUB   = 3'd1;
  localparam logic [2:0] NOT_A = 3'd5;
  localparam logic [2:0] OP7   = 3'd7;

  // Sequencer FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle   = 2'd0;
  localparam state_t StDrive  = 2'd1;
`ifdef ALU_SEQ_SETTLE_EN
  localparam state_t StSettle = 2'd2;
`endif
  localparam state_t StHold   = 2'd3;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between a requester and the ALU sequencer.
// The master is the requester/consumer; the slave is the sequencer.
interface alu_seq_if #(
  parameter int unsigned DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic              cmd_use_carry;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_carry;
  logic              res_zero;
  logic              flag_carry;
  logic              flag_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_use_carry, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_carry, res_zero, flag_carry, flag_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_use_carry, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_carry, res_zero, flag_carry, flag_zero
  );
endinterface

// File: rtl/alu_seq_flags.sv
// Capture register for the ALU result and flags; the sticky flags live here too so they
// only ever change on a capture edge or on reset.
module alu_seq_flags #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] data,
  input  logic              carry,
  input  logic              zero,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic              res_zero,
  output logic              flag_carry,
  output logic              flag_zero
);

  // Load result and flags together on capture; async clear abandons any result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_data   <= '0;
      res_carry  <= 1'b0;
      res_zero   <= 1'b0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
    end else if (capture) begin
      res_data   <= data;
      res_carry  <= carry;
      res_zero   <= zero;
      flag_carry <= carry;
      flag_zero  <= zero;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer wrapped around a 16-bit tri-state-output ALU: accepts one request, drives the ALU
// for one cycle (two when ALU_SEQ_SETTLE_EN is defined), captures result and flags, then
// offers the result on a valid/ready handshake. Requests are not pipelined.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_seq_if.slave          bus,
  output logic [DATA_W-1:0] alu_in_1,
  output logic [DATA_W-1:0] alu_in_2,
  output logic [2:0]        alu_select,
  output logic              alu_carry_in,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_carry_out,
  input  logic              alu_zero_flag
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0]        op_q;
  logic              cin_q;
  logic              accept;
  logic              capture;
  logic              flag_carry;
  logic [DATA_W-1:0] res_data;
  logic              res_carry, res_zero, flag_zero;

  assign accept = bus.cmd_valid && (state_q == StIdle);

`ifdef ALU_SEQ_SETTLE_EN
  assign capture    = (state_q == StSettle);
  assign alu_enable = (state_q == StDrive) || (state_q == StSettle);
`else
  assign capture    = (state_q == StDrive);
  assign alu_enable = (state_q == StDrive);
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.cmd_valid) state_d = StDrive;
`ifdef ALU_SEQ_SETTLE_EN
      StDrive:  state_d = StSettle;
      StSettle: state_d = StHold;
`else
      StDrive:  state_d = StHold;
`endif
      StHold:   if (bus.res_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register; async reset drops alu_enable without waiting for a clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Operand registers: loaded on accept, held while enabled, zeroed at the capture edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 3'd0;
      cin_q <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.cmd_a;
      b_q   <= bus.cmd_b;
      op_q  <= bus.cmd_op;
      cin_q <= bus.cmd_use_carry & flag_carry;
    end else if (capture) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 3'd0;
      cin_q <= 1'b0;
    end
  end

  assign alu_in_1     = a_q;
  assign alu_in_2     = b_q;
  assign alu_select   = op_q;
  assign alu_carry_in = cin_q;

  // alu_data is only sampled here, and capture is only true while alu_enable is high
  alu_seq_flags #(
    .DATA_W(DATA_W)
  ) u_flags (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture   (capture),
    .data      (alu_data),
    .carry     (alu_carry_out),
    .zero      (alu_zero_flag),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_zero  (res_zero),
    .flag_carry(flag_carry),
    .flag_zero (flag_zero)
  );

  assign bus.cmd_ready  = (state_q == StIdle);
  assign bus.res_valid  = (state_q == StHold);
  assign bus.res_data   = res_data;
  assign bus.res_carry  = res_carry;
  assign bus.res_zero   = res_zero;
  assign bus.flag_carry = flag_carry;
  assign bus.flag_zero  = flag_zero;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural tri-state ALU and a flag-tracking
// reference model. Honours ALU_SEQ_SETTLE_EN for latency and enable-width expectations.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_SETTLE_EN
  localparam int Lat = 3;
  localparam int EnCyc = 2;
  localparam int Gap = 4;
`else
  localparam int Lat = 2;
  localparam int EnCyc = 1;
  localparam int Gap = 3;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.DATA_W(16)) bus ();

  logic [15:0] alu_in_1, alu_in_2;
  logic [2:0]  alu_select;
  logic        alu_carry_in, alu_enable;
  wire  [15:0] alu_data;
  logic        alu_carry_out, alu_zero_flag;
  logic [17:0] alu_out;

  int checks = 0;
  int errors = 0;
  logic m_fc = 1'b0;
  logic m_fz = 1'b0;

  int cyc_cnt = 0;
  bit mon_on = 1'b0;
  int acc_q[$];
  logic [17:0] res_q[$];
  logic [17:0] exp_q[$];

  // ALU behaviour, packed as {carry, zero, result}; SUB reports borrow as carry
  function automatic logic [17:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    case (op)
      ADD:     begin s = 17'(a) + 17'(b) + 17'(cin); r = s[15:0]; c = s[16]; end
      SUB:     begin s = 17'(a) - 17'(b) - 17'(cin); r = s[15:0]; c = s[16]; end
      NOT_A:   begin r = ~a; c = 1'b1; end
      default: begin r = 16'd0; c = 1'b0; end
    endcase
    return {c, (r == 16'd0), r};
  endfunction

  always_comb alu_out = alu_fn(alu_select, alu_in_1, alu_in_2, alu_carry_in);
  assign alu_data      = alu_enable ? alu_out[15:0] : 16'bz;
  assign alu_carry_out = alu_out[17];
  assign alu_zero_flag = alu_out[16];

  alu_sequencer #(.DATA_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .alu_in_1     (alu_in_1),
    .alu_in_2     (alu_in_2),
    .alu_select   (alu_select),
    .alu_carry_in (alu_carry_in),
    .alu_enable   (alu_enable),
    .alu_data     (alu_data),
    .alu_carry_out(alu_carry_out),
    .alu_zero_flag(alu_zero_flag)
  );

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Handshake monitor for the back-to-back run; sees pre-edge values
  always @(posedge clk) begin
    if (mon_on) begin
      if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc_cnt);
      if (bus.res_valid && bus.res_ready)
        res_q.push_back({bus.res_carry, bus.res_zero, bus.res_data});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_en"}, 32'(alu_enable), 32'd0);
    check({tag, "_in1"}, 32'(alu_in_1), 32'd0);
    check({tag, "_in2"}, 32'(alu_in_2), 32'd0);
    check({tag, "_sel"}, 32'(alu_select), 32'd0);
    check({tag, "_cin"}, 32'(alu_carry_in), 32'd0);
    check({tag, "_rv"}, 32'(bus.res_valid), 32'd0);
  endtask

  // One request: accept, drive, capture, wait hold_cyc cycles with res_ready low, release
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic uc, input int hold_cyc, input bit poke,
                       output logic [15:0] r_out);
    logic        cin;
    logic [17:0] e;
    int          cyc, en_cnt;
    cin = uc ? m_fc : 1'b0;
    e   = alu_fn(op, a, b, cin);
    check("pre_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    bus.cmd_use_carry = uc;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    cyc = 1; en_cnt = 0;
    while (!bus.res_valid && cyc < 10) begin
      if (alu_enable) begin
        en_cnt++;
        check("drv_in1", 32'(alu_in_1), 32'(a));
        check("drv_in2", 32'(alu_in_2), 32'(b));
        check("drv_sel", 32'(alu_select), 32'(op));
        check("drv_cin", 32'(alu_carry_in), 32'(cin));
      end
      check("drv_ready", 32'(bus.cmd_ready), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(Lat));
    check("en_cycles", 32'(en_cnt), 32'(EnCyc));
    check("res_data", 32'(bus.res_data), 32'(e[15:0]));
    check("res_carry", 32'(bus.res_carry), 32'(e[17]));
    check("res_zero", 32'(bus.res_zero), 32'(e[16]));
    m_fc = e[17];
    m_fz = e[16];
    check("flag_carry", 32'(bus.flag_carry), 32'(m_fc));
    check("flag_zero", 32'(bus.flag_zero), 32'(m_fz));
    check("hold_en", 32'(alu_enable), 32'd0);
    check("hold_in1", 32'(alu_in_1), 32'd0);
    r_out = bus.res_data;
    for (int i = 0; i < hold_cyc; i++) begin
      if (poke && i == 0) begin
        bus.cmd_valid = 1'b1; bus.cmd_op = ADD; bus.cmd_a = 16'h1111; bus.cmd_b = 16'h2222;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("wait_rv", 32'(bus.res_valid), 32'd1);
      check("wait_data", 32'(bus.res_data), 32'(e[15:0]));
      check("wait_flags", 32'({bus.res_carry, bus.res_zero}), 32'(e[17:16]));
      check("wait_ready", 32'(bus.cmd_ready), 32'd0);
      check("wait_en", 32'(alu_enable), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("done_rv", 32'(bus.res_valid), 32'd0);
    check("done_ready", 32'(bus.cmd_ready), 32'd1);
    check("done_en", 32'(alu_enable), 32'd0);
  endtask

  initial begin
    logic [15:0] r;
    logic [2:0]  ops [4];
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        uc, cin, rdy;
    logic [17:0] e;
    int          n;
    ops = '{ADD, SUB, NOT_A, OP7};
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_use_carry = 1'b0;
    bus.cmd_a = 16'd0; bus.cmd_b = 16'd0; bus.res_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    check("rst_rdata", 32'(bus.res_data), 32'd0);
    check("rst_flags", 32'({bus.res_carry, bus.res_zero, bus.flag_carry, bus.flag_zero}), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios
    do_op(ADD, 16'd5, 16'd3, 1'b0, 0, 1'b0, r);
    check("plan_add", 32'(r), 32'd8);
    do_op(SUB, 16'd6035, 16'd3127, 1'b0, 5, 1'b1, r);
    check("plan_sub", 32'(r), 32'd2908);
    do_op(NOT_A, 16'hFFFF, 16'd0, 1'b0, 0, 1'b0, r);
    check("plan_not", 32'(r), 32'd0);
    check("plan_not_fc", 32'(bus.flag_carry), 32'd1);
    do_op(ADD, 16'd4941, 16'd1259, 1'b1, 1, 1'b0, r);
    check("plan_chain", 32'(r), 32'd6201);
    do_op(OP7, 16'd1, 16'd0, 1'b0, 0, 1'b0, r);
    check("plan_op7", 32'(r), 32'd0);
    check("plan_op7_fz", 32'(bus.flag_zero), 32'd1);

    // Reset while the ALU is being driven
    bus.cmd_valid = 1'b1; bus.cmd_op = ADD; bus.cmd_a = 16'd100; bus.cmd_b = 16'd200;
    bus.cmd_use_carry = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("mid_en", 32'(alu_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    check("mid_flags", 32'({bus.flag_carry, bus.flag_zero}), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_fc = 1'b0;
    m_fz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_rv", 32'(bus.res_valid), 32'd0);
    end
    do_op(ADD, 16'd1000, 16'd234, 1'b1, 0, 1'b0, r);
    check("post_rst_op", 32'(r), 32'd1234);

    // Randomised requests with random consumer back-pressure
    for (int i = 0; i < 20; i++) begin
      do_op(ops[$urandom_range(0, 3)], 16'($urandom), 16'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom), r);
    end

    // Back-to-back with res_ready tied high
    bus.res_ready = 1'b1;
    mon_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op  = ops[$urandom_range(0, 3)];
      a   = 16'($urandom);
      b   = 16'($urandom);
      uc  = 1'($urandom);
      cin = uc ? m_fc : 1'b0;
      e   = alu_fn(op, a, b, cin);
      exp_q.push_back(e);
      m_fc = e[17];
      m_fz = e[16];
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
      bus.cmd_use_carry = uc;
      n = 0;
      do begin
        rdy = bus.cmd_ready;
        @(posedge clk); #1;
        n++;
      end while (!rdy && n < 20);
      check("b2b_accept", 32'(rdy), 32'd1);
    end
    bus.cmd_valid = 1'b0;
    repeat (Gap + 2) @(posedge clk);
    #1;
    mon_on = 1'b0;
    bus.res_ready = 1'b0;
    check("b2b_acc_cnt", 32'(acc_q.size()), 32'd8);
    check("b2b_res_cnt", 32'(res_q.size()), 32'(exp_q.size()));
    for (int i = 1; i < acc_q.size(); i++)
      check("b2b_gap", 32'(acc_q[i] - acc_q[i-1]), 32'(Gap));
    for (int i = 0; i < res_q.size() && i < exp_q.size(); i++)
      check("b2b_res", 32'(res_q[i]), 32'(exp_q[i]));
    check("b2b_fc", 32'(bus.flag_carry), 32'(m_fc));
    check("b2b_fz", 32'(bus.flag_zero), 32'(m_fz));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
